btb_predictor: RTL and testbench
================================

BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 Parameter IDX_BITS, default 4, index width; the table has 2**IDX_BITS entries; legal range 2..8.
REQ-002 Parameter CTR_BITS, default 2, width of the per-entry saturating counter; legal range 1..4.
REQ-003 Parameter RAS_DEPTH, default 8, number of return-address-stack entries; must be a power of 2.
REQ-004 Port clk  in  1  single clock; all state updates on posedge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port if_pc  in  32  fetch PC.
REQ-007 Port if_instr  in  32  fetched instruction word.
REQ-008 Port pred_hit  out  1  valid entry with matching tag for if_pc.
REQ-009 Port pred_taken  out  1  redirect fetch.
REQ-010 Port pred_target  out  32  predicted next PC.
REQ-011 Port upd_valid  in  1  resolved control-flow instruction in MEM this cycle.
REQ-012 Port upd_pc  in  32  PC of the resolved instruction.
REQ-013 Port upd_instr  in  32  instruction word of the resolved instruction.
REQ-014 Port upd_taken  in  1  resolved direction (br_en; 1 for jal/jalr).
REQ-015 Port upd_target  in  32  resolved target address (alu_mem).

Function
REQ-016 Index SHALL be pc[IDX_BITS+1:2] and tag pc[31:IDX_BITS+2]; each entry SHALL hold valid, tag, 32-bit target, CTR_BITS counter and a 2-bit type (BR, JUMP, CALL, RET).
REQ-017 Lookup SHALL be combinational from if_pc: pred_hit = valid && tag match, asserted only when if_instr opcode is op_br, op_jal or op_jalr.
REQ-018 On a hit with type JUMP, CALL or RET, pred_taken SHALL be 1; on type BR, pred_taken SHALL be the counter MSB; on a miss, pred_taken=0 and pred_target=32'h0.
REQ-019 Classification: CALL = jal/jalr with rd in {x1,x5}; RET = jalr with rd=x0 and rs1 in {x1,x5}; other jal/jalr = JUMP; op_br = BR.
REQ-020 Update SHALL occur at the posedge where upd_valid=1 and the upd_instr opcode is br/jal/jalr; other opcodes SHALL be ignored.
REQ-021 Update miss: allocate (overwrite) only if upd_taken=1; write tag, target, type and valid=1; counter = 2**(CTR_BITS-1) (weakly taken).
REQ-022 Update miss with upd_taken=0: no table write.
REQ-023 Update hit: counter +1 if taken, -1 if not, saturating at 0 and 2**CTR_BITS-1; target rewritten when taken and upd_target differs.
REQ-024 Update and lookup on the same index in the same cycle: lookup SHALL return pre-update contents; the new contents are visible the following cycle.
REQ-025 No latency beyond the above: prediction 0 cycles, update 1 cycle.

Reset
REQ-026 rst=1 at posedge SHALL clear all valid bits, counters and RAS pointer/count in that cycle; upd_valid is ignored during reset.
REQ-027 From the first cycle after reset, pred_hit=0, pred_taken=0 and pred_target=32'h0 for every if_pc.

Configuration
REQ-028 Macro BTB_RAS_EN defined: a RAS of RAS_DEPTH entries SHALL be built; a CALL update pushes upd_pc+4, a RET update pops; CALL-and-RET on one instruction (jalr rd=x1, rs1=x5) SHALL replace the top entry.
REQ-029 RAS overflow SHALL wrap the pointer and overwrite the oldest entry, with count saturating at RAS_DEPTH; pop when empty SHALL be a no-op.
REQ-030 With BTB_RAS_EN, a hit of type RET with RAS non-empty SHALL drive pred_target = RAS top; otherwise the stored target is used.
REQ-031 Macro undefined: no RAS storage; RET entries behave as JUMP.

Structure
REQ-032 The btb_type_t enum and opcode-classification constants (link registers x1/x5) SHALL live in rv32i_types.
REQ-033 The RAS SHALL be a sub-module, btb_ras, instantiated only under BTB_RAS_EN.

Verification
REQ-034 Reset, then if_pc=0x60, beq -> pred_hit=0, pred_taken=0, pred_target=0.
REQ-035 Update beq @0x60 taken, target 0x40; next cycle lookup 0x60 -> hit=1, taken=1, target=0x40; two not-taken updates -> taken=0; four taken updates -> counter 3, saturates.
REQ-036 Alias: taken update jal @0x60 -> 0x100, then taken update beq @0xA0 (IDX_BITS=4, same index) -> lookup 0x60 misses, 0xA0 hits with type BR.
REQ-037 Same-cycle: update 0x60 -> 0x80 while if_pc=0x60 -> old target that cycle, 0x80 the next.
REQ-038 BTB_RAS_EN, RAS_DEPTH=8: nine CALL updates from 0x1000,0x1010,...,0x1080, then RET hits -> targets 0x1084 down to 0x1014 (eight pops), ninth pop falls back to the stored target.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I opcode constants, link-register ids and BTB entry types.
// Helper functions classify control-flow instructions for the BTB and RAS.
package rv32i_types;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    BTB_BR   = 2'd0,
    BTB_JUMP = 2'd1,
    BTB_CALL = 2'd2,
    BTB_RET  = 2'd3
  } btb_type_t;

  function automatic logic is_ctrl_flow(input logic [6:0] opcode);
    return (opcode == OP_BR) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

  // jalr with two different link registers both returns and calls (replace RAS top)
  function automatic logic is_call_ret(input logic [31:0] instr);
    return (instr[6:0] == OP_JALR) && is_link(instr[11:7]) &&
           is_link(instr[19:15]) && (instr[11:7] != instr[19:15]);
  endfunction

  function automatic btb_type_t classify(input logic [31:0] instr);
    btb_type_t t;
    t = BTB_JUMP;
    if (instr[6:0] == OP_BR)
      t = BTB_BR;
    else if (is_link(instr[11:7]))
      t = BTB_CALL;
    else if ((instr[6:0] == OP_JALR) && (instr[11:7] == 5'd0) && is_link(instr[19:15]))
      t = BTB_RET;
    return t;
  endfunction

endpackage

// File: rtl/btb_ras.sv
// Circular return-address stack; overflow overwrites the oldest entry,
// popping an empty stack does nothing, push+pop together replaces the top.
module btb_ras #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_ptr;
  logic [PW:0]   count;

  assign top_ptr = ptr - 1'b1;
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      mem[top_ptr] <= push_data;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + 1'b1;
      if (count != FULL)
        count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Define BTB_RAS_EN to add a return-address stack that predicts RET targets.
module btb_predictor
  import rv32i_types::*;
#(
  parameter int IDX_BITS  = 4,
  parameter int CTR_BITS  = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_instr,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  btb_type_t           type_q   [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_BITS-1:0] if_tag, upd_tag;
  logic                upd_en, upd_hit;
  logic                ras_empty;
  logic [31:0]         ras_top;
  btb_type_t           upd_type;

  assign if_idx   = if_pc[IDX_BITS+1:2];
  assign if_tag   = if_pc[31:IDX_BITS+2];
  assign upd_idx  = upd_pc[IDX_BITS+1:2];
  assign upd_tag  = upd_pc[31:IDX_BITS+2];
  assign upd_en   = upd_valid && is_ctrl_flow(upd_instr[6:0]);
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_type = classify(upd_instr);

`ifdef BTB_RAS_EN
  btb_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (upd_en && (upd_type == BTB_CALL)),
    .pop       (upd_en && ((upd_type == BTB_RET) || is_call_ret(upd_instr))),
    .push_data (upd_pc + 32'd4),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  assign ras_top   = 32'h0;
  assign ras_empty = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{if_instr[31:7], if_pc[1:0], upd_pc[1:0], upd_instr[31:20],
                         upd_instr[14:12], ras_top, ras_empty};

  // Lookup reads the registered table directly, so a same-cycle update is not seen yet
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    if (valid_q[if_idx] && (tag_q[if_idx] == if_tag) && is_ctrl_flow(if_instr[6:0])) begin
      pred_hit    = 1'b1;
      pred_taken  = (type_q[if_idx] == BTB_BR) ? ctr_q[if_idx][CTR_BITS-1] : 1'b1;
      pred_target = target_q[if_idx];
`ifdef BTB_RAS_EN
      if ((type_q[if_idx] == BTB_RET) && !ras_empty)
        pred_target = ras_top;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= '0;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken && (ctr_q[upd_idx] != CTR_MAX))
          ctr_q[upd_idx] <= ctr_q[upd_idx] + 1'b1;
        else if (!upd_taken && (ctr_q[upd_idx] != '0))
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 1'b1;
        if (upd_taken && (target_q[upd_idx] != upd_target))
          target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        type_q[upd_idx]   <= upd_type;
        ctr_q[upd_idx]    <= CTR_WEAK;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (default IDX_BITS=4, CTR_BITS=2).
// RAS stack-order checks are compiled in only when BTB_RAS_EN is defined.
module tb_btb_predictor;

  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_JAL   = 32'h0000_006F;
  localparam logic [31:0] I_CALL  = 32'h0000_00EF;
  localparam logic [31:0] I_RET   = 32'h0000_8067;
  localparam logic [31:0] I_ADDI  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0, if_instr = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0, upd_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_instr = '0, upd_target = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btb_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_instr   (upd_instr),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                               input logic taken, input logic [31:0] target);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_instr  = instr;
    upd_taken  = taken;
    upd_target = target;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [31:0] instr);
    if_pc    = pc;
    if_instr = instr;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_tgt;

    doReset();
    lookup(32'h60, I_BEQ);
    checkOutput("rst_hit",    pred_hit,    0);
    checkOutput("rst_taken",  pred_taken,  0);
    checkOutput("rst_target", pred_target, 0);

    applyStimulus(32'h60, I_BEQ, 1'b1, 32'h40);
    lookup(32'h60, I_BEQ);
    checkOutput("alloc_hit",    pred_hit,    1);
    checkOutput("alloc_taken",  pred_taken,  1);
    checkOutput("alloc_target", pred_target, 32'h40);

    applyStimulus(32'h60, I_BEQ, 1'b0, 32'h40);
    checkOutput("nt1_taken", pred_taken, 0);
    applyStimulus(32'h60, I_BEQ, 1'b0, 32'h40);
    checkOutput("nt2_taken", pred_taken, 0);
    checkOutput("nt2_hit",   pred_hit,   1);

    applyStimulus(32'h60, I_BEQ, 1'b1, 32'h40);
    checkOutput("t1_taken", pred_taken, 0);
    applyStimulus(32'h60, I_BEQ, 1'b1, 32'h40);
    checkOutput("t2_taken", pred_taken, 1);
    applyStimulus(32'h60, I_BEQ, 1'b1, 32'h40);
    applyStimulus(32'h60, I_BEQ, 1'b1, 32'h40);
    checkOutput("t4_taken", pred_taken, 1);
    applyStimulus(32'h60, I_BEQ, 1'b0, 32'h40);
    checkOutput("sat_hi_taken", pred_taken, 1);
    applyStimulus(32'h60, I_BEQ, 1'b0, 32'h40);
    checkOutput("sat_hi_nt2", pred_taken, 0);

    applyStimulus(32'h60, I_ADDI, 1'b1, 32'h999);
    checkOutput("ignore_taken",  pred_taken,  0);
    checkOutput("ignore_target", pred_target, 32'h40);
    lookup(32'h60, I_ADDI);
    checkOutput("nonbr_lookup_hit", pred_hit, 0);

    applyStimulus(32'h64, I_BEQ, 1'b0, 32'h50);
    lookup(32'h64, I_BEQ);
    checkOutput("nt_miss_noalloc", pred_hit, 0);

    lookup(32'h60, I_BEQ);
    upd_valid  = 1'b1;
    upd_pc     = 32'h60;
    upd_instr  = I_BEQ;
    upd_taken  = 1'b1;
    upd_target = 32'h80;
    #1;
    checkOutput("same_cyc_old_target", pred_target, 32'h40);
    checkOutput("same_cyc_old_taken",  pred_taken,  0);
    tick();
    upd_valid = 1'b0;
    checkOutput("same_cyc_new_target", pred_target, 32'h80);
    checkOutput("same_cyc_new_taken",  pred_taken,  1);

    doReset();
    lookup(32'h60, I_BEQ);
    checkOutput("rst2_hit", pred_hit, 0);

    applyStimulus(32'h60, I_JAL, 1'b1, 32'h100);
    lookup(32'h60, I_JAL);
    checkOutput("jal_hit",    pred_hit,    1);
    checkOutput("jal_taken",  pred_taken,  1);
    checkOutput("jal_target", pred_target, 32'h100);

    applyStimulus(32'hA0, I_BEQ, 1'b1, 32'h200);
    lookup(32'h60, I_JAL);
    checkOutput("alias_old_hit",    pred_hit,    0);
    checkOutput("alias_old_target", pred_target, 0);
    lookup(32'hA0, I_BEQ);
    checkOutput("alias_new_hit",    pred_hit,    1);
    checkOutput("alias_new_taken",  pred_taken,  1);
    checkOutput("alias_new_target", pred_target, 32'h200);
    applyStimulus(32'hA0, I_BEQ, 1'b0, 32'h200);
    checkOutput("alias_type_br", pred_taken, 0);

    applyStimulus(32'h2008, I_RET, 1'b1, 32'h3000);
    lookup(32'h2008, I_RET);
    checkOutput("ret_hit",    pred_hit,    1);
    checkOutput("ret_taken",  pred_taken,  1);
    checkOutput("ret_target", pred_target, 32'h3000);

`ifdef BTB_RAS_EN
    for (int i = 0; i < 9; i++)
      applyStimulus(32'h1000 + 32'(i) * 32'h10, I_CALL, 1'b1, 32'h5000);
    for (int i = 0; i < 8; i++) begin
      lookup(32'h2008, I_RET);
      exp_tgt = 32'h1084 - 32'(i) * 32'h10;
      checkOutput($sformatf("ras_pop%0d", i), pred_target, exp_tgt);
      applyStimulus(32'h2008, I_RET, 1'b1, 32'h3000);
    end
    lookup(32'h2008, I_RET);
    checkOutput("ras_empty_fallback", pred_target, 32'h3000);
`else
    exp_tgt = 32'h3000;
    applyStimulus(32'h1000, I_CALL, 1'b1, 32'h5000);
    lookup(32'h2008, I_RET);
    checkOutput("ret_as_jump_target", pred_target, exp_tgt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
